// File: rtl/wb_xbar_pkg.sv
// Shared types and helpers for the Wishbone pipelined crossbar: response tags and address decode.
package wb_xbar_pkg;
  localparam int MAX_SLV = 8;
  localparam int MAX_AW  = 32;
  localparam int TAG_W   = $clog2(MAX_SLV + 1);

  // Slave index 0..NSLV-1, value NSLV marks the internal error responder.
  typedef logic [TAG_W-1:0] tag_t;

  function automatic tag_t err_tag(input int nslv);
    return tag_t'(nslv);
  endfunction

  // Lowest-index hit wins; a miss on every slave returns the error tag.
  function automatic tag_t decode(input logic [MAX_AW-1:0]         adr,
                                  input logic [MAX_SLV*MAX_AW-1:0] base,
                                  input logic [MAX_SLV*MAX_AW-1:0] mask,
                                  input int                        nslv);
    tag_t t;
    t = tag_t'(nslv);
    for (int i = MAX_SLV - 1; i >= 0; i--) begin
      if (i < nslv && (adr & mask[i*MAX_AW +: MAX_AW]) == base[i*MAX_AW +: MAX_AW])
        t = tag_t'(i);
    end
    return t;
  endfunction
endpackage

// File: rtl/wb_pend_fifo.sv
// In-order queue of target tags for requests that are still awaiting a response.
module wb_pend_fifo
  import wb_xbar_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  tag_t                   push_tag,
  output tag_t                   head,
  output tag_t                   last_tag,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  tag_t          mem [DEPTH];

  assign head = mem[rd_ptr];
  assign full = (count == (PW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_tag;
  end

  // Flush wins over push/pop; it is used for bus abort and watchdog expiry.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (!rst_n) last_tag <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        last_tag <= push_tag;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_xbar_pipe.sv
// 1-master / NSLV-slave Wishbone B4 pipelined interconnect with in-order responses,
// an error responder for unmapped addresses and a response watchdog.
module wb_xbar_pipe
  import wb_xbar_pkg::*;
#(
  parameter int                  NSLV    = 5,
  parameter int                  AW      = 16,
  parameter int                  DW      = 16,
  parameter int                  DEPTH   = 4,
  parameter int                  TIMEOUT = 255,
  parameter logic [NSLV*AW-1:0]  BASE    = '0,
  parameter logic [NSLV*AW-1:0]  MASK    = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wbm_cyc,
  input  logic               wbm_stb,
  input  logic               wbm_we,
  input  logic [AW-1:0]      wbm_adr,
  input  logic [DW-1:0]      wbm_dat_i,
  output logic [DW-1:0]      wbm_dat_o,
  output logic               wbm_ack,
  output logic               wbm_err,
  output logic               wbm_stall,
  output logic [NSLV-1:0]    wbs_cyc,
  output logic [NSLV-1:0]    wbs_stb,
  output logic               wbs_we,
  output logic [AW-1:0]      wbs_adr,
  output logic [DW-1:0]      wbs_dat_o,
  input  logic [NSLV*DW-1:0] wbs_dat_i,
  input  logic [NSLV-1:0]    wbs_ack,
  input  logic [NSLV-1:0]    wbs_stall
);
  localparam tag_t ERR_T = err_tag(NSLV);
  localparam int   CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [MAX_SLV*MAX_AW-1:0] base_w;
  logic [MAX_SLV*MAX_AW-1:0] mask_w;
  tag_t                      tgt;
  tag_t                      head;
  tag_t                      last_tag;
  logic [$clog2(DEPTH):0]    count;
  logic                      full;
  logic                      busy;
  logic                      req;
  logic                      blk;
  logic                      sel_stall;
  logic                      head_ack;
  logic [DW-1:0]             head_dat;
  logic                      accept;
  logic                      ack;
  logic                      err_rsp;
  logic                      pop;
  logic                      tmo_fire;
  logic                      flush;
  logic                      abort_q;
  logic [CW-1:0]             wd_cnt;

  always_comb begin
    base_w = '0;
    mask_w = '0;
    for (int i = 0; i < NSLV; i++) begin
      base_w[i*MAX_AW +: AW] = BASE[i*AW +: AW];
      mask_w[i*MAX_AW +: AW] = MASK[i*AW +: AW];
    end
  end

  assign tgt  = decode(MAX_AW'(wbm_adr), base_w, mask_w, NSLV);
  assign busy = (count != '0);
  assign req  = wbm_cyc & wbm_stb;

  always_comb begin
    sel_stall = 1'b0;
    head_ack  = 1'b0;
    head_dat  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (tgt == tag_t'(i)) sel_stall = wbs_stall[i];
      if (head == tag_t'(i)) begin
        head_ack = wbs_ack[i];
        head_dat = wbs_dat_i[i*DW +: DW];
      end
    end
  end

  // Handshake: a request is accepted in any cycle with cyc & stb & !stall; each
  // accepted request gets exactly one ack or err, in acceptance order.
  assign blk       = full | (busy & (tgt != last_tag)) | ((tgt == ERR_T) & busy)
                   | abort_q | tmo_fire;
  assign wbm_stall = blk | sel_stall;
  assign accept    = rst_n & req & ~wbm_stall;

  assign ack      = rst_n & wbm_cyc & busy & (head != ERR_T) & head_ack;
  assign err_rsp  = rst_n & wbm_cyc & busy & (head == ERR_T);
  assign pop      = ack | err_rsp;
  assign tmo_fire = rst_n & (TIMEOUT != 0) & wbm_cyc & busy & ~pop
                  & (wd_cnt == CW'(TIMEOUT));
  assign flush    = tmo_fire | (rst_n & ~wbm_cyc & busy);

  assign wbm_ack   = ack;
  assign wbm_err   = err_rsp | tmo_fire;
  assign wbm_dat_o = ack ? head_dat : '0;

  assign wbs_we    = wbm_we;
  assign wbs_adr   = wbm_adr;
  assign wbs_dat_o = wbm_dat_i;

  always_comb begin
    wbs_stb = '0;
    wbs_cyc = '0;
    for (int i = 0; i < NSLV; i++) begin
      wbs_stb[i] = rst_n & req & (tgt == tag_t'(i)) & ~blk;
      wbs_cyc[i] = rst_n & wbm_cyc & ~abort_q
                 & (wbs_stb[i] | (busy & (head == tag_t'(i))));
    end
  end

  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .pop      (pop),
    .flush    (flush),
    .push_tag (tgt),
    .head     (head),
    .last_tag (last_tag),
    .count    (count),
    .full     (full)
  );

  // After a watchdog expiry all slave cycles drop for one cycle so slaves abandon the stuck access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= tmo_fire;
      if (!busy || pop || flush) wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_xbar_pipe.sv
// Directed bench for wb_xbar_pipe: ROM at 0000/E000, RAM at 2000/E000, everything else unmapped.
module tb_wb_xbar_pipe;
  localparam int NSLV = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
  localparam int W = 17;

  logic               clk;
  logic               rst_n;
  logic               wbm_cyc, wbm_stb, wbm_we;
  logic [AW-1:0]      wbm_adr;
  logic [DW-1:0]      wbm_dat_i;
  logic [DW-1:0]      wbm_dat_o;
  logic               wbm_ack, wbm_err, wbm_stall;
  logic [NSLV-1:0]    wbs_cyc, wbs_stb;
  logic               wbs_we;
  logic [AW-1:0]      wbs_adr;
  logic [DW-1:0]      wbs_dat_o;
  logic [NSLV*DW-1:0] wbs_dat_i;
  logic [NSLV-1:0]    wbs_ack, wbs_stall;

  wb_xbar_pipe #(
    .NSLV(NSLV), .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
    .BASE({16'h2000, 16'h0000}), .MASK({16'hE000, 16'hE000})
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we), .wbm_adr(wbm_adr),
    .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o), .wbm_ack(wbm_ack),
    .wbm_err(wbm_err), .wbm_stall(wbm_stall),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_adr(wbs_adr),
    .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i), .wbs_ack(wbs_ack),
    .wbs_stall(wbs_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    int          s;
    logic [15:0] adr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [W-1:0] exp_q[$];
  logic [15:0] req_q[$];

  int total, bad, cyc_no;
  int stall_n, ack_n, err_n, acc_n, acc_cyc, acc_first, err_cyc, max_cnt;
  int stb_n[NSLV];
  bit keep_cyc, tmo_expected, slv_abort_en;
  bit ack_en[NSLV];

  function automatic logic [15:0] slv_data(input int s, input logic [15:0] a);
    return (s == 0) ? (a ^ 16'h5A00) : (a ^ 16'h0C3C);
  endfunction

  function automatic logic [W-1:0] model(input logic [15:0] a);
    if ((a & 16'hE000) == 16'h0000) return {1'b0, slv_data(0, a)};
    if ((a & 16'hE000) == 16'h2000) return {1'b0, slv_data(1, a)};
    return {1'b1, 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_stats();
    stall_n = 0; ack_n = 0; err_n = 0; acc_n = 0; acc_cyc = 0; acc_first = 0;
    err_cyc = 0; max_cnt = 0;
    for (int s = 0; s < NSLV; s++) stb_n[s] = 0;
  endtask

  // One bus cycle: drive slaves and master at negedge, sample 1 ns later.
  task automatic step();
    logic         a_v;
    logic [15:0]  d_v;
    logic [W-1:0] e;
    @(negedge clk);
    for (int s = 0; s < NSLV; s++) begin
      a_v = 1'b0;
      d_v = 16'hDEAD;
      if (ack_en[s]) begin
        for (int k = 0; k < pend_q.size(); k++) begin
          if (pend_q[k].s == s) begin
            if (pend_q[k].due <= cyc_no) begin
              a_v = 1'b1;
              d_v = slv_data(s, pend_q[k].adr);
              pend_q.delete(k);
            end
            break;
          end
        end
      end
      wbs_ack[s] = a_v;
      wbs_dat_i[s*DW +: DW] = d_v;
    end
    wbm_cyc = keep_cyc || (req_q.size() > 0);
    wbm_stb = (req_q.size() > 0);
    wbm_adr = (req_q.size() > 0) ? req_q[0] : 16'h0000;
    #1;
    if (wbm_ack || wbm_err) begin
      if (wbm_err && tmo_expected) begin
        exp_q.delete();
        tmo_expected = 1'b0;
      end else if (exp_q.size() == 0) begin
        chk("unexpected_resp", {30'd0, wbm_ack, wbm_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp", 32'({wbm_err, wbm_dat_o}), 32'(e));
      end
    end
    if (wbm_ack) ack_n++;
    if (wbm_err) begin
      err_n++;
      err_cyc = cyc_no;
    end
    if (wbm_cyc && wbm_stb && wbm_stall) stall_n++;
    for (int s = 0; s < NSLV; s++) stb_n[s] += int'(wbs_stb[s]);
    if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    if (wbm_cyc && wbm_stb && !wbm_stall) begin
      exp_q.push_back(model(wbm_adr));
      void'(req_q.pop_front());
      if (acc_n == 0) acc_first = cyc_no;
      acc_n++;
      acc_cyc = cyc_no;
    end
    for (int s = 0; s < NSLV; s++)
      if (wbs_cyc[s] && wbs_stb[s] && !wbs_stall[s])
        pend_q.push_back('{s: s, adr: wbs_adr, due: cyc_no + 3});
    if (slv_abort_en)
      for (int k = pend_q.size() - 1; k >= 0; k--)
        if (!wbs_cyc[pend_q[k].s]) pend_q.delete(k);
    cyc_no++;
  endtask

  task automatic drain(input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (req_q.size() == 0 && exp_q.size() == 0) break;
      step();
    end
    chk(tag, 32'(req_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"},   {31'd0, wbm_ack}, 32'd0);
    chk({tag, "_err"},   {31'd0, wbm_err}, 32'd0);
    chk({tag, "_dat"},   {16'd0, wbm_dat_o}, 32'd0);
    chk({tag, "_cyc"},   {30'd0, wbs_cyc}, 32'd0);
    chk({tag, "_stb"},   {30'd0, wbs_stb}, 32'd0);
    chk({tag, "_stall"}, {31'd0, wbm_stall}, 32'd0);
    chk({tag, "_count"}, 32'(dut.u_fifo.count), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; cyc_no = 0;
    rst_n = 1'b0;
    wbm_cyc = 1'b0; wbm_stb = 1'b0; wbm_we = 1'b0; wbm_adr = '0; wbm_dat_i = '0;
    wbs_dat_i = '0; wbs_ack = '0; wbs_stall = '0;
    keep_cyc = 1'b0; tmo_expected = 1'b0; slv_abort_en = 1'b1;
    ack_en[0] = 1'b1; ack_en[1] = 1'b1;
    reset_stats();
    repeat (3) step();
    chk_idle("reset");
    rst_n = 1'b1;
    step();

    // pipelined ROM reads
    reset_stats();
    keep_cyc = 1'b1;
    req_q = '{16'h0000, 16'h0002, 16'h0004};
    drain("t1_drain", 30);
    chk("t1_acks", 32'(ack_n), 32'd3);
    chk("t1_max_count", 32'(max_cnt), 32'd3);
    keep_cyc = 1'b0;
    step();

    // ROM then RAM: RAM held off until ROM response pops
    reset_stats();
    keep_cyc = 1'b1;
    req_q = '{16'h0000, 16'h2000};
    drain("t2_drain", 30);
    chk("t2_stall_cycles", 32'(stall_n), 32'd3);
    chk("t2_rom_stb", 32'(stb_n[0]), 32'd1);
    chk("t2_ram_stb", 32'(stb_n[1]), 32'd1);
    chk("t2_acks", 32'(ack_n), 32'd2);
    keep_cyc = 1'b0;
    step();

    // unmapped address
    reset_stats();
    keep_cyc = 1'b1;
    req_q = '{16'hF000};
    drain("t3_drain", 10);
    chk("t3_err_count", 32'(err_n), 32'd1);
    chk("t3_err_latency", 32'(err_cyc - acc_cyc), 32'd1);
    chk("t3_no_stb", 32'(stb_n[0] + stb_n[1]), 32'd0);
    keep_cyc = 1'b0;
    step();

    // silent slave: FIFO fills, watchdog expires
    reset_stats();
    keep_cyc = 1'b1;
    ack_en[0] = 1'b0;
    tmo_expected = 1'b1;
    req_q = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
    for (int i = 0; i < 40; i++) begin
      if (err_n > 0) break;
      step();
    end
    chk("t4_timeout_err", 32'(err_n), 32'd1);
    chk("t4_err_cycle", 32'(err_cyc - acc_first), 32'd17);
    chk("t4_fifth_stalled", 32'(stall_n), 32'd14);
    chk("t4_accepts", 32'(acc_n), 32'd4);
    tmo_expected = 1'b0;
    step();
    chk("t4_cyc_dropped", {30'd0, wbs_cyc}, 32'd0);
    chk("t4_hold_stall", {31'd0, wbm_stall}, 32'd1);
    chk("t4_count_flushed", 32'(dut.u_fifo.count), 32'd0);
    ack_en[0] = 1'b1;
    drain("t4_drain", 20);
    chk("t4_fifth_ack", 32'(ack_n), 32'd1);
    keep_cyc = 1'b0;
    step();

    // master abort with two outstanding, late slave acks
    reset_stats();
    slv_abort_en = 1'b0;
    keep_cyc = 1'b1;
    req_q = '{16'h0000, 16'h0002};
    for (int i = 0; i < 10; i++) begin
      if (acc_n == 2) break;
      step();
    end
    chk("t5_accepts", 32'(acc_n), 32'd2);
    keep_cyc = 1'b0;
    exp_q.delete();
    step();
    keep_cyc = 1'b1;
    repeat (4) step();
    chk("t5_no_ack", 32'(ack_n), 32'd0);
    chk("t5_count", 32'(dut.u_fifo.count), 32'd0);
    keep_cyc = 1'b0;
    slv_abort_en = 1'b1;
    pend_q.delete();
    step();

    // reset mid-burst, then fresh RAM read
    reset_stats();
    keep_cyc = 1'b1;
    req_q = '{16'h0000, 16'h0002, 16'h0004};
    for (int i = 0; i < 10; i++) begin
      if (acc_n == 2) break;
      step();
    end
    rst_n = 1'b0;
    req_q.delete();
    keep_cyc = 1'b0;
    exp_q.delete();
    pend_q.delete();
    step();
    rst_n = 1'b1;
    step();
    chk_idle("t6_after_reset");
    reset_stats();
    keep_cyc = 1'b1;
    req_q = '{16'h2000};
    drain("t6_drain", 20);
    chk("t6_acks", 32'(ack_n), 32'd1);
    keep_cyc = 1'b0;
    step();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
